// File: rtl/pc_unit_pkg.sv
// Shared encodings for the multicycle core: PC source selects, branch funct3
// codes and the base opcodes decoded by the control unit.
package pc_unit_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // funct3 010/011 carry no branch meaning under OP_BRANCH
  function automatic logic is_rsvd_branch(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// Combinational RISC-V branch condition evaluator; flags reserved funct3 codes.
module branch_cmp
  import pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  always_comb begin
    rs1_s = rs1;
    rs2_s = rs2;
    eq    = (rs1 == rs2);
    lt_s  = (rs1_s < rs2_s);
    lt_u  = (rs1 < rs2);
    illegal = is_rsvd_branch(funct3);
    taken = 1'b0;
    case (funct3)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BLT:     taken = lt_s;
      BGE:     taken = ~lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage of the multicycle core: PC/old_pc registers, branch
// resolution, misaligned-target trapping and a fetched-instruction counter.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic            PCSource1,
  input  logic            PCSource0,
  input  logic            IRWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  input  logic            trap_clear,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            branch_taken,
  output logic            misaligned,
  output logic            bad_branch,
  output logic [XLEN-1:0] trap_addr,
  output logic [63:0]     fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic            misaligned_q, misaligned_d;
  logic            bad_branch_q, bad_branch_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  logic [63:0]     fetch_count_q, fetch_count_d;

  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] target;
  logic            update;
  logic            flags_clear;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (funct3),
    .rs1     (rs1_data),
    .rs2     (rs2_data),
    .taken   (taken),
    .illegal (illegal)
  );

  always_comb begin
    case ({PCSource1, PCSource0})
      PCSRC_ALU:    target = alu_result;
      PCSRC_ALUOUT: target = alu_out;
      PCSRC_JALR:   target = {alu_result[XLEN-1:1], 1'b0};
      default:      target = pc_q;
    endcase
    // A raised PCWrite makes the cycle unconditional; taken only matters without it
    update      = PCWrite | (PCWriteCond & taken);
    flags_clear = ~misaligned_q & ~bad_branch_q;

    pc_d          = pc_q;
    old_pc_d      = old_pc_q;
    misaligned_d  = misaligned_q;
    bad_branch_d  = bad_branch_q;
    trap_addr_d   = trap_addr_q;
    fetch_count_d = fetch_count_q;

    if (trap_clear) begin
      misaligned_d = 1'b0;
      bad_branch_d = 1'b0;
      trap_addr_d  = '0;
    end
    if (update) begin
      if (target[1:0] == 2'b00) begin
        pc_d = target;
      end else if (flags_clear || trap_clear) begin
        misaligned_d = 1'b1;
        trap_addr_d  = target;
      end
    end
    if (PCWriteCond && !PCWrite && illegal) bad_branch_d = 1'b1;
    if (IRWrite) begin
      old_pc_d      = pc_q;
      fetch_count_d = fetch_count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      old_pc_q      <= RESET_VECTOR;
      misaligned_q  <= 1'b0;
      bad_branch_q  <= 1'b0;
      trap_addr_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      misaligned_q  <= misaligned_d;
      bad_branch_q  <= bad_branch_d;
      trap_addr_q   <= trap_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc           = pc_q;
  assign old_pc       = old_pc_q;
  assign branch_taken = taken;
  assign misaligned   = misaligned_q;
  assign bad_branch   = bad_branch_q;
  assign trap_addr    = trap_addr_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written reset/fetch sequences
// and a randomized run against a behavioural model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, PCSource1, PCSource0, IRWrite, trap_clear;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, alu_result, alu_out;
  logic [31:0] pc, old_pc, trap_addr;
  logic        branch_taken, misaligned, bad_branch;
  logic [63:0] fetch_count;

  int checks = 0;
  int errors = 0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource1(PCSource1), .PCSource0(PCSource0), .IRWrite(IRWrite),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_result(alu_result), .alu_out(alu_out), .trap_clear(trap_clear),
    .pc(pc), .old_pc(old_pc), .branch_taken(branch_taken),
    .misaligned(misaligned), .bad_branch(bad_branch), .trap_addr(trap_addr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, pw, pwc, clr;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, ares, aout;
    logic        tk;
    logic [31:0] pc, old;
    logic        mis, bad;
    logic [31:0] trap;
    int          fc;
  } vec_t;

  vec_t tbl[$];

  // behavioural reference state
  logic [31:0] m_pc, m_old, m_trap;
  logic        m_mis, m_bad;
  logic [63:0] m_fc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ir, pw, pwc, input logic [1:0] src, input logic [2:0] f3,
                     input logic [31:0] rs1, rs2, ares, aout, input logic clr,
                     input logic tk, input logic [31:0] epc, eold, input logic mis, bad,
                     input logic [31:0] trap, input int fc);
    vec_t v;
    v.ir = ir; v.pw = pw; v.pwc = pwc; v.src = src; v.f3 = f3;
    v.rs1 = rs1; v.rs2 = rs2; v.ares = ares; v.aout = aout; v.clr = clr;
    v.tk = tk; v.pc = epc; v.old = eold; v.mis = mis; v.bad = bad; v.trap = trap; v.fc = fc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ir, pw, pwc, input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] rs1, rs2, ares, aout, input logic clr);
    IRWrite = ir; PCWrite = pw; PCWriteCond = pwc;
    PCSource1 = src[1]; PCSource0 = src[0]; funct3 = f3;
    rs1_data = rs1; rs2_data = rs2; alu_result = ares; alu_out = aout; trap_clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic ir, pw, pwc, input logic [1:0] src, input logic [2:0] f3,
                            input logic [31:0] rs1, rs2, ares, aout, input logic clr);
    logic [31:0] tgt;
    logic        do_upd;
    logic        was_clear;
    logic [31:0] prev_pc;
    prev_pc   = m_pc;
    was_clear = !m_mis && !m_bad;
    case (src)
      2'd0: tgt = ares;
      2'd1: tgt = aout;
      2'd2: tgt = ares - (ares % 2);
      default: tgt = m_pc;
    endcase
    do_upd = pw || (pwc && ref_taken(f3, rs1, rs2));
    if (clr) begin m_mis = 0; m_bad = 0; m_trap = 0; end
    if (do_upd) begin
      if (tgt % 4 == 0) m_pc = tgt;
      else if (was_clear || clr) begin m_mis = 1; m_trap = tgt; end
    end
    if (pwc && !pw && (f3 == 3'd2 || f3 == 3'd3)) m_bad = 1;
    if (ir) begin m_old = prev_pc; m_fc = m_fc + 1; end
  endtask

  initial begin
    logic [31:0] r, ares, aout, a, b;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic        ir, pw, pwc, clr;

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_old_pc", old_pc, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_bad_branch", bad_branch, 0);
    chk("rst_trap_addr", trap_addr, 0);
    chk("rst_fetch_count", fetch_count, 0);
    @(negedge clk);
    reset = 1'b0;

    //   ir pw pwc src    f3      rs1           rs2           ares          aout        clr  tk  pc          old         mis bad trap        fc
    add(1, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h4,        32'h0,       0,  0, 32'h4,      32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b000, 32'h5,        32'h5,        32'h0,        32'h40,      0,  1, 32'h40,     32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b001, 32'h5,        32'h5,        32'h0,        32'h80,      0,  0, 32'h40,     32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b100, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h80,      0,  1, 32'h80,     32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b110, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h100,     0,  0, 32'h80,     32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b111, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h100,     0,  1, 32'h100,    32'h0,      0, 0, 32'h0,      1);
    add(0, 0, 1, 2'b01, 3'b101, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h200,     0,  0, 32'h100,    32'h0,      0, 0, 32'h0,      1);
    add(1, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h104,      32'h0,       0,  0, 32'h104,    32'h100,    0, 0, 32'h0,      2);
    add(0, 1, 0, 2'b10, 3'b010, 32'h0,        32'h0,        32'h103,      32'h0,       0,  0, 32'h104,    32'h100,    1, 0, 32'h102,    2);
    add(0, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h10A,      32'h0,       0,  0, 32'h104,    32'h100,    1, 0, 32'h102,    2);
    add(0, 0, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h0,        32'h0,       1,  0, 32'h104,    32'h100,    0, 0, 32'h0,      2);
    add(0, 0, 1, 2'b01, 3'b010, 32'h0,        32'h0,        32'h0,        32'h200,     0,  0, 32'h104,    32'h100,    0, 1, 32'h0,      2);
    add(0, 0, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h0,        32'h0,       1,  0, 32'h104,    32'h100,    0, 0, 32'h0,      2);
    add(0, 1, 0, 2'b11, 3'b010, 32'h0,        32'h0,        32'h300,      32'h0,       0,  0, 32'h104,    32'h100,    0, 0, 32'h0,      2);
    add(0, 1, 1, 2'b01, 3'b001, 32'h5,        32'h5,        32'h0,        32'h208,     0,  0, 32'h208,    32'h100,    0, 0, 32'h0,      2);
    add(0, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h20E,      32'h0,       0,  0, 32'h208,    32'h100,    1, 0, 32'h20E,    2);
    add(0, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h301,      32'h0,       1,  0, 32'h208,    32'h100,    1, 0, 32'h301,    2);
    add(0, 0, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h0,        32'h0,       1,  0, 32'h208,    32'h100,    0, 0, 32'h0,      2);
    add(0, 0, 1, 2'b01, 3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h0,        32'h400,     0,  1, 32'h400,    32'h100,    0, 0, 32'h0,      2);
    add(0, 0, 1, 2'b01, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h0,        32'h404,     0,  1, 32'h404,    32'h100,    0, 0, 32'h0,      2);
    add(0, 0, 1, 2'b01, 3'b011, 32'h0,        32'h0,        32'h0,        32'h500,     0,  0, 32'h404,    32'h100,    0, 1, 32'h0,      2);
    add(0, 1, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h3,        32'h0,       0,  0, 32'h404,    32'h100,    0, 1, 32'h0,      2);
    add(0, 0, 0, 2'b00, 3'b010, 32'h0,        32'h0,        32'h0,        32'h0,       1,  0, 32'h404,    32'h100,    0, 0, 32'h0,      2);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ir, tbl[i].pw, tbl[i].pwc, tbl[i].src, tbl[i].f3,
            tbl[i].rs1, tbl[i].rs2, tbl[i].ares, tbl[i].aout, tbl[i].clr);
      #1;
      chk($sformatf("v%0d_taken", i), branch_taken, tbl[i].tk);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_old_pc", i), old_pc, tbl[i].old);
      chk($sformatf("v%0d_misaligned", i), misaligned, tbl[i].mis);
      chk($sformatf("v%0d_bad_branch", i), bad_branch, tbl[i].bad);
      chk($sformatf("v%0d_trap_addr", i), trap_addr, tbl[i].trap);
      chk($sformatf("v%0d_fetch_count", i), fetch_count, 64'(tbl[i].fc));
    end

    // IRWrite alone: old_pc captures pc, counter advances, pc holds
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      r = $urandom;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 3'b010, r, r, r, r, 1'b0);
      @(posedge clk);
      #1;
      chk("irw_pc_hold", pc, 32'h404);
      chk("irw_old_pc", old_pc, 32'h404);
      chk("irw_fetch_count", fetch_count, 64'(3 + k));
    end

    // Fetch to 0x80, set a sticky flag, then async reset between edges
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b010, 32'h0, 32'h0, 32'h80, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_pc", pc, 32'h80);
    chk("pre_rst_old_pc", old_pc, 32'h404);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_bad_branch", bad_branch, 1);
    @(negedge clk);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_old_pc", old_pc, 0);
    chk("async_rst_fetch_count", fetch_count, 0);
    chk("async_rst_bad_branch", bad_branch, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized run against the reference model
    m_pc = 0; m_old = 0; m_trap = 0; m_mis = 0; m_bad = 0; m_fc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ir  = ($urandom_range(0, 9) < 3);
      pw  = ($urandom_range(0, 9) < 3);
      pwc = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 9) == 0);
      src = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      r = $urandom;
      ares = (r & ~32'h3) | (($urandom_range(0, 3) == 0) ? (32'($urandom) & 32'h3) : 32'h0);
      r = $urandom;
      aout = (r & ~32'h3) | (($urandom_range(0, 5) == 0) ? (32'($urandom) & 32'h3) : 32'h0);
      drive(ir, pw, pwc, src, f3, a, b, ares, aout, clr);
      #1;
      chk("rnd_taken", branch_taken, ref_taken(f3, a, b));
      model_step(ir, pw, pwc, src, f3, a, b, ares, aout, clr);
      @(posedge clk);
      #1;
      chk("rnd_pc", pc, m_pc);
      chk("rnd_old_pc", old_pc, m_old);
      chk("rnd_misaligned", misaligned, m_mis);
      chk("rnd_bad_branch", bad_branch, m_bad);
      chk("rnd_trap_addr", trap_addr, m_trap);
      chk("rnd_fetch_count", fetch_count, m_fc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
